// File: rtl/pdp_mem_arbiter.sv
// Single-port memory arbiter between PDP-8 instruction fetch and execute requesters.
// Define PDP_ARB_RR_EN for round-robin fetch/exec priority instead of fixed exec priority with starvation forcing.
module pdp_mem_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 12,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_rd_req,
   input  logic [ADDR_WIDTH-1:0] fetch_rd_addr,
   output logic                  fetch_done,
   output logic [DATA_WIDTH-1:0] fetch_rd_data,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_done,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

   state_t     state;
   logic       owner_exec;
   logic [2:0] wait_cnt;
   logic       grant_fetch;
   logic       grant_exec_wr;
   logic       grant_exec_rd;

`ifdef PDP_ARB_RR_EN
   logic last_owner_exec;

   // On contention the requester that did not win last time gets the grant.
   always_comb begin
      grant_fetch   = 1'b0;
      grant_exec_wr = 1'b0;
      grant_exec_rd = 1'b0;
      if ((exec_wr_req || exec_rd_req) && (!fetch_rd_req || !last_owner_exec)) begin
         if (exec_wr_req)
            grant_exec_wr = 1'b1;
         else
            grant_exec_rd = 1'b1;
      end else if (fetch_rd_req) begin
         grant_fetch = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_owner_exec <= 1'b0;
      else if (state == IDLE && (grant_exec_wr || grant_exec_rd))
         last_owner_exec <= 1'b1;
      else if (state == IDLE && grant_fetch)
         last_owner_exec <= 1'b0;
   end
`else
   localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;
   logic          force_fetch;

   always_comb begin
      force_fetch   = (STARVE_LIMIT != 0) && fetch_rd_req && (starve_cnt == STARVE_MAX);
      grant_fetch   = 1'b0;
      grant_exec_wr = 1'b0;
      grant_exec_rd = 1'b0;
      if (force_fetch)
         grant_fetch = 1'b1;
      else if (exec_wr_req)
         grant_exec_wr = 1'b1;
      else if (exec_rd_req)
         grant_exec_rd = 1'b1;
      else if (fetch_rd_req)
         grant_fetch = 1'b1;
   end

   // Counts exec grants that passed over a waiting fetch; saturates at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (!fetch_rd_req || grant_fetch)
            starve_cnt <= '0;
         else if ((grant_exec_wr || grant_exec_rd) && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         owner_exec    <= 1'b0;
         wait_cnt      <= 3'd0;
         busy          <= 1'b0;
         fetch_done    <= 1'b0;
         fetch_rd_data <= '0;
         exec_done     <= 1'b0;
         exec_rd_data  <= '0;
         mem_rd_req    <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_req    <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
      end else begin
         fetch_done  <= 1'b0;
         exec_done   <= 1'b0;
         mem_rd_req  <= 1'b0;
         mem_rd_addr <= '0;
         mem_wr_req  <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         case (state)
            IDLE: begin
               if (grant_exec_wr) begin
                  owner_exec  <= 1'b1;
                  mem_wr_req  <= 1'b1;
                  mem_wr_addr <= exec_wr_addr;
                  mem_wr_data <= exec_wr_data;
                  busy        <= 1'b1;
                  state       <= WR_ISSUE;
               end else if (grant_exec_rd) begin
                  owner_exec  <= 1'b1;
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= exec_rd_addr;
                  busy        <= 1'b1;
                  state       <= RD_ISSUE;
               end else if (grant_fetch) begin
                  owner_exec  <= 1'b0;
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= fetch_rd_addr;
                  busy        <= 1'b1;
                  state       <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               wait_cnt <= WAIT_INIT;
               state    <= RD_WAIT;
            end
            // Read data is valid RD_LAT cycles after the issue cycle.
            RD_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  if (owner_exec) begin
                     exec_rd_data <= mem_rd_data;
                     exec_done    <= 1'b1;
                  end else begin
                     fetch_rd_data <= mem_rd_data;
                     fetch_done    <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WR_ISSUE: begin
               exec_done <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pdp_mem_arbiter.md
Name: pdp_mem_arbiter

Overview:
- Single-port memory access controller between the two PDP-8 memory requesters, instruction fetch (decode side) and instruction execute, and the shared memory_pdp port.
- Grants one request at a time and sequences the read-latency wait.
- Returns read data to the winner with a one-cycle done pulse.
- Execute wins by default; a starvation counter guarantees fetch forward progress.

Parameters:
- ADDR_WIDTH, 12, memory address width (PDP-8 word address).
- DATA_WIDTH, 12, memory data width.
- RD_LAT, 1, cycles from mem_rd_req high to mem_rd_data valid; legal 1..7.
- STARVE_LIMIT, 3, consecutive exec grants while fetch pending before fetch is forced; 0 disables forcing.

Ports:
- clk  in  1  free-running clock
- reset  in  1  synchronous, active-high reset
- fetch_rd_req  in  1  fetch read request, level, held until fetch_done
- fetch_rd_addr  in  ADDR_WIDTH  fetch address, stable while req high
- fetch_done  out  1  one-cycle pulse: fetch_rd_data valid
- fetch_rd_data  out  DATA_WIDTH  fetched word
- exec_rd_req  in  1  exec read request, level
- exec_rd_addr  in  ADDR_WIDTH  exec read address
- exec_wr_req  in  1  exec write request, level
- exec_wr_addr  in  ADDR_WIDTH  exec write address
- exec_wr_data  in  DATA_WIDTH  exec write data
- exec_done  out  1  one-cycle pulse: exec access complete; exec_rd_data valid if read
- exec_rd_data  out  DATA_WIDTH  exec read word
- mem_rd_req  out  1  read strobe to memory_pdp
- mem_rd_addr  out  ADDR_WIDTH  read address to memory_pdp
- mem_rd_data  in  DATA_WIDTH  read data from memory_pdp
- mem_wr_req  out  1  write strobe to memory_pdp
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  DATA_WIDTH  write data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all outputs registered and 0 on reset; FSM goes to IDLE; starvation counter 0. Reset mid-access aborts it: no done pulse, and an in-flight memory read is discarded.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- IDLE: arbitrate among the requests sampled this cycle.
  - Priority: exec_wr > exec_rd > fetch_rd.
  - Exception: if STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT with fetch_rd_req high, fetch wins.
  - Winner latched (owner, address, write data). Read goes to RD_ISSUE; write goes to WR_ISSUE; no request stays in IDLE.
- RD_ISSUE: mem_rd_req=1 and mem_rd_addr=latched address for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - Wait counter loaded with RD_LAT-1 and decrements each cycle.
  - When it reaches 0, capture mem_rd_data into the owner's rd_data register and go to DONE.
  - Data is sampled exactly RD_LAT cycles after the RD_ISSUE cycle.
- WR_ISSUE: mem_wr_req=1 with latched address and data for exactly one cycle, then DONE.
- DONE: owner's done=1 for one cycle, then IDLE. rd_data holds its value until the next capture for that owner.
- Requester handshake:
  - Requesters deassert req on the clock edge at which done is sampled high.
  - A req still high in IDLE after DONE is treated as a new request.
- Latency: read done at cycle N+2+RD_LAT, write done at N+2, where N is the IDLE cycle in which the request is sampled.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when exec is granted while fetch_rd_req is high.
  - Clears when fetch is granted or fetch_rd_req is low in IDLE.
- Boundary cases:
  - Exec rd and wr both high: write served first, read in the next arbitration.
  - Request changes while not IDLE: ignored until the next IDLE.
  - mem_rd_req and mem_wr_req are never high together.
- Throughput: back-to-back accesses carry one IDLE bubble.

Optional Feature:
- Macro PDP_ARB_RR_EN.
- Defined: exec (rd/wr combined) and fetch alternate priority round-robin. A one-bit last_owner register, reset to fetch, means exec wins the first contested grant. The starvation counter is not built and STARVE_LIMIT is ignored.
- Undefined: fixed exec priority with the starvation counter, as described above.

Test Plan:
- Reset, then fetch_rd_req=1 addr 0o200, memory holds 0o7300 at 0o200, RD_LAT=1 -> mem_rd_req one cycle with addr 0o200; fetch_done at cycle 3 after sampling with fetch_rd_data=0o7300; busy low after.
- exec_wr_req addr 0o050 data 0o1234 -> single mem_wr_req cycle with those values; exec_done 2 cycles after sampling; mem_rd_req stays 0.
- fetch and exec_rd both held continuously, STARVE_LIMIT=3 -> grant order exec,exec,exec,fetch,exec... and a fetch_done occurs within 4 exec completions.
- RD_LAT=4, exec_rd addr 0o017 -> data sampled 4 cycles after mem_rd_req; exec_done at cycle 6.
- reset asserted during RD_WAIT -> no done pulse; all outputs 0 the next cycle; a subsequent request completes normally.
- PDP_ARB_RR_EN defined, both requesters continuously active -> strict alternation exec,fetch,exec,fetch.
